// File: rtl/pal_timing.sv
// PAL progressive composite-sync and active-window timing generator.
// All outputs are registered decodes of the (hc, vc) position held before each edge.
module pal_timing #(
  parameter int unsigned H_TOTAL     = 914,
  parameter int unsigned H_HALF      = 457,
  parameter int unsigned H_SYNC      = 67,
  parameter int unsigned H_EQ        = 34,
  parameter int unsigned H_BROAD     = 390,
  parameter int unsigned H_ACT_START = 150,
  parameter int unsigned H_ACT_LEN   = 743,
  parameter int unsigned V_TOTAL     = 312,
  parameter int unsigned V_ACT_START = 22,
  parameter int unsigned V_ACT_LEN   = 288
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       en,
  output logic       sync_n,
  output logic       active,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  typedef enum logic [1:0] {
    LINE_NORMAL,
    LINE_EQ,
    LINE_BROAD
  } line_kind_e;

  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic          sync_n_q, sync_n_d;
  logic          active_q, active_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  int unsigned   hc_u, vc_u, pulse_w;
  line_kind_e    kind;
  logic          sync_low, in_act;

  always_comb begin
    hc_u = 32'(hc_q);
    vc_u = 32'(vc_q);
  end

  // Vertical-interval lines carry a second pulse at the half-line point.
  always_comb begin
    kind = LINE_NORMAL;
    if (vc_u < 3) begin
      kind = LINE_BROAD;
    end else if ((vc_u < 5) || (vc_u >= V_TOTAL - 2)) begin
      kind = LINE_EQ;
    end
  end

  always_comb begin
    pulse_w = H_SYNC;
    case (kind)
      LINE_BROAD: pulse_w = H_BROAD;
      LINE_EQ:    pulse_w = H_EQ;
      default:    pulse_w = H_SYNC;
    endcase
    sync_low = (hc_u < pulse_w) ||
               ((kind != LINE_NORMAL) && (hc_u >= H_HALF) && (hc_u < H_HALF + pulse_w));
    in_act   = (vc_u >= V_ACT_START) && (vc_u < V_ACT_START + V_ACT_LEN) &&
               (hc_u >= H_ACT_START) && (hc_u < H_ACT_START + H_ACT_LEN);
  end

  always_comb begin
    hc_d          = hc_q;
    vc_d          = vc_q;
    sync_n_d      = sync_n_q;
    active_d      = active_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (en) begin
      sync_n_d      = ~sync_low;
      active_d      = in_act;
      x_d           = in_act ? 10'(hc_u - H_ACT_START) : '0;
      y_d           = in_act ? 9'(vc_u - V_ACT_START) : '0;
      line_start_d  = (hc_u == 0);
      frame_start_d = (hc_u == 0) && (vc_u == 0);
      if (hc_u == H_TOTAL - 1) begin
        hc_d = '0;
        vc_d = (vc_u == V_TOTAL - 1) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      sync_n_q      <= 1'b1;
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      sync_n_q      <= sync_n_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sync_n      = sync_n_q;
  assign active      = active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pal_timing.sv
// Scoreboard bench for pal_timing using a scaled-down raster so full frames stay short.
module tb_pal_timing;

  localparam int unsigned HT  = 100;
  localparam int unsigned HH  = 50;
  localparam int unsigned HS  = 8;
  localparam int unsigned HE  = 4;
  localparam int unsigned HB  = 40;
  localparam int unsigned HAS = 15;
  localparam int unsigned HAL = 80;
  localparam int unsigned VT  = 40;
  localparam int unsigned VAS = 6;
  localparam int unsigned VAL = 30;

  typedef struct packed {
    logic       sync_n;
    logic       active;
    logic [9:0] x;
    logic [8:0] y;
    logic       ls;
    logic       fs;
  } exp_t;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sync_n, active, line_start, frame_start;
  logic [9:0] x;
  logic [8:0] y;

  exp_t q[$];
  exp_t last_exp;
  exp_t reset_exp;
  int   checks = 0;
  int   failures = 0;
  int   mhc = 0;
  int   mvc = 0;
  int   nfs = 0;
  int   cyc = 0;
  int   act_cnt = 0;
  int   viol = 0;

  pal_timing #(
    .H_TOTAL(HT), .H_HALF(HH), .H_SYNC(HS), .H_EQ(HE), .H_BROAD(HB),
    .H_ACT_START(HAS), .H_ACT_LEN(HAL),
    .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT_LEN(VAL)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .en(en),
    .sync_n(sync_n), .active(active), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 pclk = ~pclk;

  function automatic void cmp(input string name, input int unsigned got, input int unsigned want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  function automatic exp_t model(input int h, input int v);
    exp_t e;
    int   w;
    bool_dummy: begin end
    e = '0;
    if (v < 3)                    w = HB;
    else if (v < 5 || v >= VT-2)  w = HE;
    else                          w = HS;
    e.sync_n = !((h < w) || (w != HS && h >= HH && h < HH + w));
    e.active = (v >= VAS && v < VAS + VAL && h >= HAS && h < HAS + HAL);
    e.x      = e.active ? 10'(h - HAS) : 10'd0;
    e.y      = e.active ? 9'(v - VAS) : 9'd0;
    e.ls     = (h == 0);
    e.fs     = (h == 0 && v == 0);
    return e;
  endfunction

  task automatic step(input logic e);
    en = e;
    @(posedge pclk);
    if (e) begin
      last_exp = model(mhc, mvc);
      mhc++;
      if (mhc == HT) begin
        mhc = 0;
        mvc = (mvc == VT - 1) ? 0 : mvc + 1;
      end
    end else begin
      last_exp.ls = 1'b0;
      last_exp.fs = 1'b0;
    end
    q.push_back(last_exp);
    @(negedge pclk);
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(mhc == h && mvc == v) && n < 2 * HT * VT) begin
      step(1'b1);
      n++;
    end
    cmp("run_to_reached", (mhc == h && mvc == v), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_sync_n"}, sync_n, 1);
    cmp({tag, "_active"}, active, 0);
    cmp({tag, "_x"}, x, 0);
    cmp({tag, "_y"}, y, 0);
    cmp({tag, "_line_start"}, line_start, 0);
    cmp({tag, "_frame_start"}, frame_start, 0);
  endtask

  // Monitor: pops one expectation per stepped cycle and keeps frame-level tallies.
  always @(negedge pclk) begin
    exp_t e, got;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {sync_n, active, x, y, line_start, frame_start};
      cmp("cycle_outputs", got, e);
      if (frame_start) begin
        if (nfs == 1) begin
          cmp("frame_period", cyc, HT * VT);
          cmp("active_count", act_cnt, HAL * VAL);
        end
        nfs++;
        cyc = 0;
        act_cnt = 0;
      end
      cyc++;
      if (active) act_cnt++;
      if (active && !sync_n) viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_exp = '0;
    reset_exp.sync_n = 1'b1;
    last_exp = reset_exp;

    #23;
    check_reset_outputs("por");

    @(negedge pclk);
    #2 rst_n = 1'b1;
    step(1'b0);
    step(1'b0);

    // First frame uninterrupted, then freeze mid-line in the second frame.
    repeat (HT * VT) step(1'b1);
    run_to(20, 8);
    repeat (10) step(1'b0);
    run_to(50, 20);

    #2;
    cmp("queue_drained_before_reset", q.size(), 0);
    en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    #10 check_reset_outputs("held");
    @(negedge pclk);
    #2 rst_n = 1'b1;
    mhc = 0;
    mvc = 0;
    last_exp = reset_exp;
    repeat (6 * HT) step(1'b1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge pclk);
    #1;
    cmp("queue_drained_end", q.size(), 0);
    cmp("sync_active_overlap", viol, 0);
    cmp("frame_start_count", nfs, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pal_timing.md
PAL_TIMING -- requirements
Module: pal_timing

Interface
REQ-001 SHALL have parameter H_TOTAL, default 914: pclk cycles per line (70 ns pixel, ~64 us line).
REQ-002 SHALL have parameter H_HALF, default 457: half-line offset for second vertical-interval pulse.
REQ-003 SHALL have parameter H_SYNC, default 67: normal line sync width (~4.7 us).
REQ-004 SHALL have parameter H_EQ, default 34: equalizing pulse width (~2.35 us).
REQ-005 SHALL have parameter H_BROAD, default 390: broad pulse width (~27.3 us).
REQ-006 SHALL have parameter H_ACT_START, default 150, and H_ACT_LEN, default 743: active video window in pixels.
REQ-007 SHALL have parameter V_TOTAL, default 312, V_ACT_START, default 22, V_ACT_LEN, default 288: progressive PAL lines.
REQ-008 SHALL have port pclk  input  1  pixel clock, all logic on rising edge.
REQ-009 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-010 SHALL have port en  input  1  count enable; low freezes timing.
REQ-011 SHALL have port sync_n  output  1  composite sync, active low.
REQ-012 SHALL have port active  output  1  high inside active picture area.
REQ-013 SHALL have port x  output  10  pixel index in active area, 0 outside.
REQ-014 SHALL have port y  output  9  line index in active area, 0 outside.
REQ-015 SHALL have port line_start  output  1  one-cycle pulse at hc=0.
REQ-016 SHALL have port frame_start  output  1  one-cycle pulse at hc=0, vc=0.
REQ-017 SHALL satisfy: one clock; reset is asynchronous and active-low (ports pclk and rst_n).

Function
REQ-018 SHALL keep internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1).
REQ-019 With en=1, hc SHALL increment each pclk; at H_TOTAL-1 it SHALL wrap to 0 and vc SHALL increment; at vc=V_TOTAL-1 with hc wrap, vc SHALL wrap to 0.
REQ-020 With en=0, hc, vc and all outputs SHALL hold, except line_start and frame_start which SHALL be 0.
REQ-021 All outputs SHALL be registered decodes of (hc,vc): outputs after edge k+1 describe counter value held before edge k+1 (latency 1 cycle).
REQ-022 vc 0..2 (broad lines): sync_n SHALL be 0 for hc in [0,H_BROAD) and [H_HALF,H_HALF+H_BROAD), else 1.
REQ-023 vc 3..4 and V_TOTAL-2..V_TOTAL-1 (equalizing): sync_n SHALL be 0 for hc in [0,H_EQ) and [H_HALF,H_HALF+H_EQ), else 1.
REQ-024 All other lines: sync_n SHALL be 0 for hc in [0,H_SYNC), else 1.
REQ-025 active SHALL be 1 iff vc in [V_ACT_START,V_ACT_START+V_ACT_LEN) and hc in [H_ACT_START,H_ACT_START+H_ACT_LEN).
REQ-026 When active=1, x SHALL equal hc-H_ACT_START (0..742) and y SHALL equal vc-V_ACT_START (0..287); when active=0, x and y SHALL be 0.
REQ-027 active and sync_n SHALL never be simultaneously 1 and 0 respectively (no active pixel during sync).
REQ-028 Arithmetic SHALL be unsigned; subtraction results SHALL be truncated to output width with no overflow for default parameters.

Reset
REQ-029 rst_n=0 SHALL immediately force hc=0, vc=0, sync_n=1, active=0, x=0, y=0, line_start=0, frame_start=0, independent of pclk.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; after release, first rising edge with en=1 SHALL output position (0,0): sync_n=0, line_start=1, frame_start=1.
REQ-031 Reset release SHALL be the only way to resynchronize; no other restart input exists.

Verification
REQ-032 Reset release, en=1 -> first edge: frame_start=1, line_start=1, sync_n=0; frame_start next repeats exactly 914*312=285168 cycles later.
REQ-033 Normal line vc=100 -> sync_n low exactly 67 cycles from hc=0; active high 743 cycles with x 0..742 starting at hc=150; y=78.
REQ-034 Lines vc=0..2 -> two low pulses of 390 cycles at hc=0 and hc=457; lines 3,4,310,311 -> two 34-cycle pulses at hc=0 and 457.
REQ-035 en toggled low for 10 cycles at hc=200,vc=50 -> outputs frozen, line/frame pulses 0; resumes at hc=200 with no skipped position.
REQ-036 rst_n pulsed low at hc=500,vc=200 between edges -> outputs reset asynchronously; sequence restarts per REQ-030.
REQ-037 Full-frame check -> active count 743*288=213984 per frame; active never 1 while sync_n=0; x,y 0 whenever active=0.
